// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit general-purpose register file for the decode path.
// One synchronous write port (WB stage), two combinational read ports.
// Register 0 is hardwired to zero.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   When defined, a read of the register being written in the same cycle
//   returns write_data directly (WB -> ID same-cycle bypass).
module reg_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0] regs_d [REG_NUM];

  // Same-cycle write hit per read port; constant zero without the bypass
  logic bypass_1;
  logic bypass_2;

`ifdef REGFILE_WRITE_BYPASS_EN
  assign bypass_1 = write_en && (write_addr == read_addr_1);
  assign bypass_2 = write_en && (write_addr == read_addr_2);
`else
  assign bypass_1 = 1'b0;
  assign bypass_2 = 1'b0;
`endif

  // Next-state of the array: only a non-zero write address changes anything
  always_comb begin
    regs_d = regs_q;
    if (write_en && (write_addr != '0)) begin
      regs_d[write_addr] = write_data;
    end
    regs_d[0] = '0;
  end

  // Register storage; reset clears every entry without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Port 1 read: reset, disabled and r0 all force zero; bypass beats storage
  always_comb begin
    read_data_1 = '0;
    if (!rst && read_en_1 && (read_addr_1 != '0)) begin
      if (bypass_1) begin
        read_data_1 = write_data;
      end else begin
        read_data_1 = regs_q[read_addr_1];
      end
    end
  end

  // Port 2 read: identical priority, fully independent of port 1
  always_comb begin
    read_data_2 = '0;
    if (!rst && read_en_2 && (read_addr_2 != '0)) begin
      if (bypass_2) begin
        read_data_2 = write_data;
      end else begin
        read_data_2 = regs_q[read_addr_2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file.
// Directed vector table, hand-written reset / hazard sequences, then
// randomized traffic checked against an array-based reference model.
// Expectations honour REGFILE_WRITE_BYPASS_EN when it is defined.
module tb_reg_file;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        read_en_1;
  logic [4:0]  read_addr_1;
  logic [31:0] read_data_1;
  logic        read_en_2;
  logic [4:0]  read_addr_2;
  logic [31:0] read_data_2;

  int checks;
  int errors;

  // reference model: plain array of register contents
  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [9];

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_en_1   (read_en_1),
    .read_addr_1 (read_addr_1),
    .read_data_1 (read_data_1),
    .read_en_2   (read_en_2),
    .read_addr_2 (read_addr_2),
    .read_data_2 (read_data_2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // advance one rising edge; the model commits the write the DUT should see
  task automatic tick();
    @(posedge clk);
    if (!rst && write_en && write_addr != 5'd0) model[write_addr] = write_data;
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
    write_en    = we;
    write_addr  = wa;
    write_data  = wd;
    read_en_1   = re1;
    read_addr_1 = ra1;
    read_en_2   = re2;
    read_addr_2 = ra2;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected read value derived from the read priority rules
  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] addr);
    if (rst) return 32'h0;
    if (!en) return 32'h0;
    if (addr == 5'd0) return 32'h0;
    if (BYPASS && write_en && write_addr == addr) return write_data;
    return model[addr];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    clear_model();

    // directed table (starts from an all-zero file, no same-cycle conflicts)
    vecs[0] = '{1'b1, 5'd7,  32'h12345678, 1'b1, 5'd1,  1'b0, 5'd7,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd3,  32'h0000000A, 1'b1, 5'd7,  1'b0, 5'd7,  32'h12345678, 32'h0};
    vecs[2] = '{1'b1, 5'd9,  32'h0000000B, 1'b1, 5'd3,  1'b1, 5'd7,  32'h0000000A, 32'h12345678};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd3,  1'b1, 5'd9,  32'h0000000A, 32'h0000000B};
    vecs[4] = '{1'b0, 5'd5,  32'h00000055, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd9,  32'h0000000B, 32'h0000000B};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd3,  32'h0,        32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd30, 1'b1, 5'd3,  32'h0,        32'h0000000A};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd0,  32'hCAFEF00D, 32'h0};

    // reset state
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
    #2;
    check("reset_rd1", read_data_1, 32'h0);
    check("reset_rd2", read_data_2, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
      #1;
      check($sformatf("vec%0d_rd1", i), read_data_1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), read_data_2, vecs[i].e2);
      tick();
    end

    // same-cycle read/write of r4: old 0x1, new 0x2
    drive(1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd4, 32'h2, 1'b1, 5'd4, 1'b1, 5'd4);
    #1;
    check("hazard_r4_same", read_data_1, BYPASS ? 32'h2 : 32'h1);
    check("hazard_r4_same_p2", read_data_2, BYPASS ? 32'h2 : 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4);
    #1;
    check("hazard_r4_next", read_data_1, 32'h2);
    check("hazard_r4_p2_disabled", read_data_2, 32'h0);
    tick();

    // simultaneous write and read of r0
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    check("r0_wr_rd1", read_data_1, 32'h0);
    check("r0_wr_rd2", read_data_2, 32'h0);
    tick();

    // reset mid-cycle clears r5; a write during reset is lost
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
    #1;
    check("r5_before_rst", read_data_1, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    check("r5_async_rst", read_data_1, 32'h0);
    drive(1'b1, 5'd6, 32'h66666666, 1'b1, 5'd5, 1'b1, 5'd6);
    #1;
    check("rd2_during_rst", read_data_2, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
    #1;
    check("r5_after_rst", read_data_1, 32'h0);
    check("r6_write_in_rst", read_data_2, 32'h0);
    // first write right after reset release lands on the next edge
    drive(1'b1, 5'd6, 32'h00C0FFEE, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd0);
    #1;
    check("r6_first_write", read_data_1, 32'h00C0FFEE);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 7)),
            $urandom_range(0, 4) != 0,
            ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 60) == 0) begin
        #1;
        rst = 1'b1;
        clear_model();
      end
      #1;
      exp_q.push_back(exp_rd(read_en_1, read_addr_1));
      exp_q.push_back(exp_rd(read_en_2, read_addr_2));
      check($sformatf("rand%0d_rd1", n), read_data_1, exp_q.pop_front());
      check($sformatf("rand%0d_rd2", n), read_data_2, exp_q.pop_front());
      tick();
      rst = 1'b0;
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
